// File: rtl/pe_db.sv
// pe_db: systolic-array MAC cell with double-buffered weights, WS and OS dataflows
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   mode, signed_en, sat_en     0=WS/1=OS, two's-complement enable, saturation enable
//   in_west[_valid]             activation from the west, forwarded east
//   in_north_weight             weight load chain (WS) or streamed operand (OS)
//   in_weight_load/_swap        shadow capture / shadow-to-active copy, forwarded south
//   in_north_psum[_valid]       partial sum (WS) or drain chain (OS) from above
//   in_drain                    OS: emit the accumulator south, forwarded south
//   out_*                       registered copies of the pass-through inputs and the result chain
module pe_db #(
  parameter int IN_DATA_WIDTH  = 8,
  parameter int OUT_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      signed_en,
  input  logic                      sat_en,
  input  logic [IN_DATA_WIDTH-1:0]  in_west,
  input  logic                      in_west_valid,
  input  logic [IN_DATA_WIDTH-1:0]  in_north_weight,
  input  logic                      in_weight_load,
  input  logic                      in_weight_swap,
  input  logic [OUT_DATA_WIDTH-1:0] in_north_psum,
  input  logic                      in_north_psum_valid,
  input  logic                      in_drain,
  output logic [IN_DATA_WIDTH-1:0]  out_east,
  output logic                      out_east_valid,
  output logic [IN_DATA_WIDTH-1:0]  out_south_weight,
  output logic                      out_weight_load,
  output logic                      out_weight_swap,
  output logic                      out_drain,
  output logic [OUT_DATA_WIDTH-1:0] out_south_psum,
  output logic                      out_south_psum_valid
);
  localparam int N = IN_DATA_WIDTH;
  localparam int O = OUT_DATA_WIDTH;
  logic [N-1:0]   shadow_w, active_w, operand;
  logic [O-1:0]   acc, addend, res;
  logic [2*N-1:0] prod;
  logic [O:0]     p_ext, sum;
  logic           mode_q, signed_q, cfg_init, cfg_chg;
  assign operand = mode ? in_north_weight : active_w;
  // Extending both operands to 2N bits makes the low 2N product bits exact for either signedness
  assign prod    = {{N{signed_en & in_west[N-1]}}, in_west} * {{N{signed_en & operand[N-1]}}, operand};
  assign p_ext   = {{(O + 1 - 2 * N){signed_en & prod[2*N-1]}}, prod};
  assign addend  = mode ? acc : in_north_psum;
  assign sum     = p_ext + {signed_en & addend[O-1], addend};
  // Signed overflow shows as disagreement of the top two bits; sum[O] then picks min or max
  assign res     = !sat_en ? sum[O-1:0] :
                   signed_en ? ((sum[O] ^ sum[O-1]) ? {sum[O], {(O - 1){~sum[O]}}} : sum[O-1:0]) :
                   (sum[O] ? '1 : sum[O-1:0]);
  // cfg_init suppresses a spurious change detection on the first edge after reset
  assign cfg_chg = cfg_init & ((mode ^ mode_q) | (signed_en ^ signed_q));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_w             <= '0;
      active_w             <= '0;
      acc                  <= '0;
      mode_q               <= 1'b0;
      signed_q             <= 1'b0;
      cfg_init             <= 1'b0;
      out_east             <= '0;
      out_east_valid       <= 1'b0;
      out_south_weight     <= '0;
      out_weight_load      <= 1'b0;
      out_weight_swap      <= 1'b0;
      out_drain            <= 1'b0;
      out_south_psum       <= '0;
      out_south_psum_valid <= 1'b0;
    end else begin
      out_east         <= in_west;
      out_east_valid   <= in_west_valid;
      out_south_weight <= in_north_weight;
      out_weight_load  <= in_weight_load;
      out_weight_swap  <= in_weight_swap;
      out_drain        <= in_drain;
      mode_q           <= mode;
      signed_q         <= signed_en;
      cfg_init         <= 1'b1;
      if (in_weight_load) shadow_w <= in_north_weight;
      if (in_weight_swap) active_w <= shadow_w;
      if (cfg_chg) begin
        acc                  <= '0;
        out_south_psum_valid <= 1'b0;
      end else if (!mode) begin
        acc                  <= '0;
        out_south_psum       <= in_west_valid ? res : out_south_psum;
        out_south_psum_valid <= in_west_valid;
      end else if (in_drain) begin
        // Draining restarts the accumulator with this cycle's product so tiles run back to back
        out_south_psum       <= acc;
        out_south_psum_valid <= 1'b1;
        acc                  <= in_west_valid ? p_ext[O-1:0] : '0;
      end else begin
        out_south_psum       <= in_north_psum;
        out_south_psum_valid <= in_north_psum_valid;
        acc                  <= in_west_valid ? res : acc;
      end
    end
  end
endmodule

// File: tb/tb_pe_db.sv
// tb_pe_db: scoreboard bench for pe_db (IN=8, OUT=16)
module tb_pe_db;
  localparam int N = 8;
  localparam int O = 16;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, signed_en = 1'b0, sat_en = 1'b1;
  logic [N-1:0] in_west = '0, in_north_weight = '0;
  logic in_west_valid = 1'b0, in_weight_load = 1'b0, in_weight_swap = 1'b0, in_drain = 1'b0;
  logic [O-1:0] in_north_psum = '0;
  logic in_north_psum_valid = 1'b0;
  logic [N-1:0] out_east, out_south_weight;
  logic out_east_valid, out_weight_load, out_weight_swap, out_drain, out_south_psum_valid;
  logic [O-1:0] out_south_psum;
  logic [O-1:0] exp_q[$];
  logic [O-1:0] e;
  int checks = 0, passed = 0;

  pe_db #(.IN_DATA_WIDTH(N), .OUT_DATA_WIDTH(O)) dut (
    .clk(clk), .rst(rst), .mode(mode), .signed_en(signed_en), .sat_en(sat_en),
    .in_west(in_west), .in_west_valid(in_west_valid), .in_north_weight(in_north_weight),
    .in_weight_load(in_weight_load), .in_weight_swap(in_weight_swap),
    .in_north_psum(in_north_psum), .in_north_psum_valid(in_north_psum_valid), .in_drain(in_drain),
    .out_east(out_east), .out_east_valid(out_east_valid), .out_south_weight(out_south_weight),
    .out_weight_load(out_weight_load), .out_weight_swap(out_weight_swap), .out_drain(out_drain),
    .out_south_psum(out_south_psum), .out_south_psum_valid(out_south_psum_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] w_act, input logic wv, input logic [N-1:0] wt, input logic ld,
                       input logic sw, input logic [O-1:0] ps, input logic pv, input logic dr);
    in_west = w_act; in_west_valid = wv; in_north_weight = wt; in_weight_load = ld;
    in_weight_swap = sw; in_north_psum = ps; in_north_psum_valid = pv; in_drain = dr;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++;
    if ({out_east, out_east_valid, out_south_weight, out_weight_load, out_weight_swap, out_drain, out_south_psum, out_south_psum_valid} !== '0)
      $display("FAIL reset_outputs got psum=%h valid=%b east=%h", out_south_psum, out_south_psum_valid, out_east);
    else passed++;
    rst = 1'b0;
    drive(8'h11, 1, 8'h22, 1, 0, 16'h1234, 1, 0);
    tick;
    drive(8'h11, 1, 8'h22, 1, 1, 16'h1234, 1, 0);
    tick;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_east, out_east_valid, out_south_weight, out_weight_load, out_weight_swap, out_drain, out_south_psum, out_south_psum_valid} !== '0)
      $display("FAIL async_reset_outputs got psum=%h valid=%b east=%h", out_south_psum, out_south_psum_valid, out_east);
    else passed++;
    checks++;
    if ({dut.acc, dut.shadow_w, dut.active_w} !== '0)
      $display("FAIL async_reset_state got acc=%h shadow=%h active=%h required 0", dut.acc, dut.shadow_w, dut.active_w);
    else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    drive(0, 0, 8'd3, 1, 0, 0, 0, 0);
    tick;
    drive(0, 0, 8'd3, 0, 1, 0, 0, 0);
    tick;
    drive(8'd4, 1, 0, 0, 0, 16'd10, 0, 0);
    exp_q.push_back(16'd22);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL post_reset_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL post_reset_psum got %0d required %0d", out_south_psum, e); else passed++; end
  endtask

  task automatic test_double_buffer;
    drive(0, 0, 8'd2, 1, 0, 0, 0, 0);
    tick;
    drive(0, 0, 8'd2, 0, 1, 0, 0, 0);
    tick;
    drive(8'd1, 1, 8'd5, 1, 0, 0, 0, 0);
    exp_q.push_back(16'd2);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL db_load_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL db_load_psum got %0d required %0d", out_south_psum, e); else passed++; end
    checks++;
    if ({out_east, out_east_valid, out_south_weight, out_weight_load} !== {8'd1, 1'b1, 8'd5, 1'b1})
      $display("FAIL passthrough got east=%h v=%b w=%h ld=%b required 01 1 05 1", out_east, out_east_valid, out_south_weight, out_weight_load);
    else passed++;
    drive(8'd1, 1, 8'd0, 0, 1, 0, 0, 0);
    exp_q.push_back(16'd2);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL db_swap_cycle_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL db_swap_cycle_psum got %0d required %0d", out_south_psum, e); else passed++; end
    drive(8'd1, 1, 8'd0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'd5);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL db_after_swap_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL db_after_swap_psum got %0d required %0d", out_south_psum, e); else passed++; end
    drive(0, 0, 8'd7, 1, 1, 0, 0, 0);
    tick;
    checks++;
    if ({dut.active_w, dut.shadow_w} !== {8'd5, 8'd7}) $display("FAIL load_swap_same got active=%0d shadow=%0d required 5 7", dut.active_w, dut.shadow_w);
    else passed++;
    checks++;
    if ({out_south_psum_valid, out_south_psum} !== {1'b0, 16'd5}) $display("FAIL ws_hold got valid=%b psum=%0d required 0 5", out_south_psum_valid, out_south_psum);
    else passed++;
  endtask

  task automatic test_signed_sat;
    signed_en = 1'b1;
    drive(0, 0, 8'h80, 1, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    tick;
    sat_en = 1'b1;
    drive(8'h80, 1, 0, 0, 0, 16'h7FFF, 0, 0);
    exp_q.push_back(16'h7FFF);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL signed_sat_max_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL signed_sat_max got %h required %h", out_south_psum, e); else passed++; end
    sat_en = 1'b0;
    exp_q.push_back(16'hBFFF);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL signed_wrap_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL signed_wrap got %h required %h", out_south_psum, e); else passed++; end
    sat_en = 1'b1;
    drive(8'h7F, 1, 0, 0, 0, 16'h8000, 0, 0);
    exp_q.push_back(16'h8000);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL signed_sat_min_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL signed_sat_min got %h required %h", out_south_psum, e); else passed++; end
    signed_en = 1'b0;
    drive(0, 0, 8'hFF, 1, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    tick;
    drive(8'hFF, 1, 0, 0, 0, 16'hFFFF, 0, 0);
    exp_q.push_back(16'hFFFF);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL unsigned_sat_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL unsigned_sat got %h required %h", out_south_psum, e); else passed++; end
    sat_en = 1'b0;
    exp_q.push_back(16'hFE00);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL unsigned_wrap_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL unsigned_wrap got %h required %h", out_south_psum, e); else passed++; end
    sat_en = 1'b1;
  endtask

  task automatic test_os_drain;
    mode = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    drive(8'd1, 1, 8'd2, 0, 0, 0, 0, 0); tick;
    drive(8'd3, 1, 8'd4, 0, 0, 0, 0, 0); tick;
    drive(8'd5, 1, 8'd6, 0, 0, 0, 0, 0); tick;
    checks++;
    if (dut.acc !== 16'd44) $display("FAIL os_acc got %0d required 44", dut.acc); else passed++;
    drive(8'd2, 1, 8'd2, 0, 0, 0, 0, 1);
    exp_q.push_back(16'd44);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL os_drain_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL os_drain got %0d required %0d", out_south_psum, e); else passed++; end
    checks++;
    if ({dut.acc, out_drain} !== {16'd4, 1'b1}) $display("FAIL os_restart got acc=%0d drain=%b required 4 1", dut.acc, out_drain); else passed++;
    drive(8'd3, 1, 8'd3, 0, 0, 0, 0, 1);
    exp_q.push_back(16'd4);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL os_b2b_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL os_b2b got %0d required %0d", out_south_psum, e); else passed++; end
    checks++;
    if (dut.acc !== 16'd9) $display("FAIL os_b2b_acc got %0d required 9", dut.acc); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b0) $display("FAIL os_idle_valid got %b required 0", out_south_psum_valid); else passed++;
  endtask

  task automatic test_os_chain;
    drive(0, 0, 0, 0, 0, 16'd99, 1, 0);
    exp_q.push_back(16'd99);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL os_chain_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL os_chain got %0d required %0d", out_south_psum, e); else passed++; end
    drive(0, 0, 0, 0, 0, 16'd99, 1, 1);
    exp_q.push_back(16'd9);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL os_drain_priority_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL os_drain_priority got %0d required %0d", out_south_psum, e); else passed++; end
    checks++;
    if (dut.acc !== 16'd0) $display("FAIL os_drain_clear got %0d required 0", dut.acc); else passed++;
  endtask

  task automatic test_mode_switch;
    drive(8'd1, 1, 8'd2, 0, 0, 0, 0, 0); tick;
    drive(8'd3, 1, 8'd4, 0, 0, 0, 0, 0); tick;
    drive(8'd5, 1, 8'd6, 0, 0, 16'd7, 1, 0);
    exp_q.push_back(16'd7);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL ms_chain_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL ms_chain got %0d required %0d", out_south_psum, e); else passed++; end
    checks++;
    if (dut.acc !== 16'd44) $display("FAIL ms_acc got %0d required 44", dut.acc); else passed++;
    mode = 1'b0;
    drive(8'd4, 1, 0, 0, 0, 16'd1, 0, 0);
    tick;
    checks++;
    if ({dut.acc, out_south_psum_valid} !== {16'd0, 1'b0}) $display("FAIL ms_clear got acc=%0d valid=%b required 0 0", dut.acc, out_south_psum_valid); else passed++;
    checks++;
    if ({dut.active_w, dut.shadow_w} !== {8'hFF, 8'hFF}) $display("FAIL ms_weights got active=%h shadow=%h required ff ff", dut.active_w, dut.shadow_w); else passed++;
    exp_q.push_back(16'd1021);
    tick;
    checks++;
    if (out_south_psum_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL ms_ws_valid got %b required 1", out_south_psum_valid);
    else begin e = exp_q.pop_front(); if (out_south_psum !== e) $display("FAIL ms_ws got %0d required %0d", out_south_psum, e); else passed++; end
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drained got %0d entries required 0", exp_q.size()); else passed++;
  endtask

  initial begin
    test_reset;
    test_double_buffer;
    test_signed_sat;
    test_os_drain;
    test_os_chain;
    test_mode_switch;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
